// File: rtl/obi_mem_responder.sv
// OBI-style memory responder: single-port word RAM with byte-enable writes,
// in-order fixed-latency responses, an outstanding limit and out-of-range error replies.
module obi_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_OUTSTANDING);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_data [LATENCY];
  logic [PW-1:0]      r_pending;

  logic [PW-1:0] w_pending_eff;
  logic [PW-1:0] w_pending_nxt;
  logic [29:0]   w_word_idx;
  logic [AW-1:0] w_mem_idx;
  logic          w_in_range;
  logic          w_accept;
  logic          w_retire;
  logic          w_rsp_err;
  logic [31:0]   w_rsp_data;
  logic          w_unused;

  assign w_word_idx = addr_i[31:2];
  assign w_mem_idx  = w_word_idx[AW-1:0];
  assign w_in_range = ((w_word_idx >> AW) == 30'd0);
  assign w_unused   = ^addr_i[1:0];

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign w_retire      = r_vld[LATENCY-1];
  assign w_pending_eff = r_pending - PW'(w_retire);
  assign gnt_o         = req_i & ~stall_i & ~rst_i & (w_pending_eff < MAX_P);
  assign w_accept      = req_i & gnt_o;

  always_comb begin
    w_rsp_err  = 1'b0;
    w_rsp_data = '0;
    if (w_accept) begin
      if (!w_in_range) begin
        w_rsp_err  = 1'b1;
        w_rsp_data = ERR_DATA;
      end else if (!we_i) begin
        w_rsp_data = r_mem[w_mem_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && we_i && w_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) r_mem[w_mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Idle stages carry zero data so rdata_o/err_o are 0 whenever rvalid_o is low.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_rsp_err;
      r_data[0] <= w_rsp_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_accept && !w_retire) begin
      w_pending_nxt = r_pending + PW'(1);
    end else if (!w_accept && w_retire) begin
      w_pending_nxt = r_pending - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      a_no_overflow: assert (r_pending <= MAX_P);
      a_no_underflow: assert (!(w_retire && (r_pending == '0)));
    end
  end

  assign rvalid_o = r_vld[LATENCY-1];
  assign err_o    = r_err[LATENCY-1];
  assign rdata_o  = r_data[LATENCY-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench: a LATENCY=1 and a LATENCY=3 responder driven by directed steps,
// responses checked against a reference RAM model with expected arrival cycles.
module tb_obi_mem_responder;

  localparam int unsigned DEPTH = 64;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  logic        d1_rst, d1_req, d1_we, d1_stall, d1_gnt, d1_rvalid, d1_err;
  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic [3:0]  d1_be;
  logic        d3_rst, d3_req, d3_we, d3_stall, d3_gnt, d3_rvalid, d3_err;
  logic [31:0] d3_addr, d3_wdata, d3_rdata;
  logic [3:0]  d3_be;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] m [2][DEPTH];

  obi_mem_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(1), .MAX_OUTSTANDING(2), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut1 (
    .clk(clk), .rst_i(d1_rst), .req_i(d1_req), .addr_i(d1_addr), .we_i(d1_we),
    .be_i(d1_be), .wdata_i(d1_wdata), .stall_i(d1_stall), .gnt_o(d1_gnt),
    .rvalid_o(d1_rvalid), .rdata_o(d1_rdata), .err_o(d1_err)
  );

  obi_mem_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(3), .MAX_OUTSTANDING(2), .ERR_DATA(32'hDEAD_BEEF)
  ) u_dut3 (
    .clk(clk), .rst_i(d3_rst), .req_i(d3_req), .addr_i(d3_addr), .we_i(d3_we),
    .be_i(d3_be), .wdata_i(d3_wdata), .stall_i(d3_stall), .gnt_o(d3_gnt),
    .rvalid_o(d3_rvalid), .rdata_o(d3_rdata), .err_o(d3_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_accept(input int d, input logic we, input logic [31:0] a,
                                        input logic [3:0] be, input logic [31:0] wd,
                                        input int lat);
    exp_t        e;
    logic [29:0] idx;
    idx    = a[31:2];
    e.cyc  = cyc + lat;
    e.err  = 1'b0;
    e.data = '0;
    if (idx >= 30'(DEPTH)) begin
      e.err  = 1'b1;
      e.data = 32'hDEAD_BEEF;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) m[d][idx[5:0]][8*k +: 8] = wd[8*k +: 8];
      end
    end else begin
      e.data = m[d][idx[5:0]];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (d1_rvalid) begin
      if (q1.size() == 0) chk("d1_spurious_rvalid", {63'd0, d1_rvalid}, 64'd0);
      else begin
        e = q1.pop_front();
        chk("d1_rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("d1_rsp_err", {63'd0, d1_err}, {63'd0, e.err});
        chk("d1_rsp_data", {32'd0, d1_rdata}, {32'd0, e.data});
      end
    end else begin
      chk("d1_idle_zero", {31'd0, d1_err, d1_rdata}, 64'd0);
    end
    if (d1_req && d1_gnt) q1.push_back(model_accept(0, d1_we, d1_addr, d1_be, d1_wdata, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (d3_rvalid) begin
      if (q3.size() == 0) chk("d3_spurious_rvalid", {63'd0, d3_rvalid}, 64'd0);
      else begin
        e = q3.pop_front();
        chk("d3_rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("d3_rsp_err", {63'd0, d3_err}, {63'd0, e.err});
        chk("d3_rsp_data", {32'd0, d3_rdata}, {32'd0, e.data});
      end
    end else begin
      chk("d3_idle_zero", {31'd0, d3_err, d3_rdata}, 64'd0);
    end
    if (d3_req && d3_gnt) q3.push_back(model_accept(1, d3_we, d3_addr, d3_be, d3_wdata, 3));
  end

  task automatic drive(input int d, input logic req, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (d == 0) begin
      d1_req = req; d1_we = we; d1_addr = a; d1_be = be; d1_wdata = wd;
    end else begin
      d3_req = req; d3_we = we; d3_addr = a; d3_be = be; d3_wdata = wd;
    end
  endtask

  // Holds the request until granted; called just after a rising edge.
  task automatic tx(input int d, input logic we, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd);
    logic g;
    g = 1'b0;
    drive(d, 1'b1, we, a, be, wd);
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      g = (d == 0) ? d1_gnt : d3_gnt;
      @(posedge clk);
      #1;
    end
    drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    chk("tx_grant_timeout", {63'd0, g}, 64'd1);
  endtask

  task automatic drain(input int d);
    int n;
    n = (d == 0) ? q1.size() : q3.size();
    for (int i = 0; i < 50 && n != 0; i++) begin
      @(posedge clk);
      #1;
      n = (d == 0) ? q1.size() : q3.size();
    end
    chk("drain_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    logic       g;
    int         k;
    for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m[d][i] = '0;
    d1_rst = 1'b1; d3_rst = 1'b1; d1_stall = 1'b0; d3_stall = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt_d1", {63'd0, d1_gnt}, 64'd0);
      chk("rst_gnt_d3", {63'd0, d3_gnt}, 64'd0);
      chk("rst_rvalid_d1", {63'd0, d1_rvalid}, 64'd0);
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    d1_rst = 1'b0; d3_rst = 1'b0;

    // Full write, read back, partial write, read back.
    tx(0, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
    tx(0, 1'b0, 32'h10, 4'h0, 32'h0);
    tx(0, 1'b1, 32'h10, 4'b0100, 32'h00AB_0000);
    tx(0, 1'b0, 32'h10, 4'h0, 32'h0);
    tx(0, 1'b1, 32'h0, 4'hF, 32'hA5A5_0001);
    tx(0, 1'b1, 32'hFC, 4'b1001, 32'h7700_0033);
    tx(0, 1'b0, 32'hFC, 4'h0, 32'h0);
    drain(0);

    // Out of range: error replies, dropped write, no aliasing onto low words.
    tx(0, 1'b0, 32'h100, 4'h0, 32'h0);
    tx(0, 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF);
    tx(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
    tx(0, 1'b0, 32'h0, 4'h0, 32'h0);
    tx(0, 1'b0, 32'h10, 4'h0, 32'h0);
    tx(0, 1'b0, 32'hFC, 4'h0, 32'h0);
    drain(0);

    // Stall holds grant low; release grants in the same cycle.
    d1_stall = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_gnt", {63'd0, d1_gnt}, 64'd0);
      @(posedge clk);
      #1;
    end
    d1_stall = 1'b0;
    #1;
    chk("unstall_gnt_same_cycle", {63'd0, d1_gnt}, 64'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drain(0);

    // LATENCY=3, MAX_OUTSTANDING=2 grant throttling.
    for (int i = 0; i < 4; i++) tx(1, 1'b1, 32'(4 * i), 4'hF, 32'h0C0D_E000 + 32'(i));
    tx(1, 1'b1, 32'h14, 4'hF, 32'hCAFE_F00D);
    drain(1);
    pat = 5'b11011;
    k = 0;
    drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      g = d3_gnt;
      chk($sformatf("d3_gnt_pat%0d", c), {63'd0, g}, {63'd0, pat[4-c]});
      @(posedge clk);
      #1;
      if (g) begin
        k++;
        d3_addr = 32'(4 * k);
        if (k == 4) d3_req = 1'b0;
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drain(1);

    // Reset with two reads in flight: both are discarded, RAM survives.
    tx(1, 1'b0, 32'h0, 4'h0, 32'h0);
    tx(1, 1'b0, 32'h4, 4'h0, 32'h0);
    d3_rst = 1'b1;
    @(posedge clk);
    #1;
    q3.delete();
    d3_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_gnt", {63'd0, d3_gnt}, 64'd1);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drain(1);
    repeat (4) @(posedge clk);
    #1;

    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q3_empty", 64'(q3.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_mem_responder.md
# obi_mem_responder

Memory-side responder for the core's OBI-style instruction and data buses. It answers `req`/`gnt` address-phase requests and returns `rvalid`/`rdata` responses in order after a configurable latency. It provides a word-addressed RAM with byte-enable writes, a limit on outstanding transactions, an externally forced grant stall, and error responses for out-of-range accesses. One instance sits opposite the core's instruction port and one opposite its data port in the testbench and FPGA top.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words. Power of two, at least 2.
- `LATENCY`, default 1: cycles from the accept cycle to the `rvalid_o` cycle. Legal range 1..8.
- `MAX_OUTSTANDING`, default 2: maximum number of accepted transactions not yet responded. Legal range 1..8.
- `ERR_DATA`, default 32'hDEAD_BEEF: value driven on `rdata_o` for an error response.

Ports:
- `clk` input, 1 bit: the single clock; everything is sampled on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `req_i` input, 1 bit: address-phase request.
- `addr_i` input, 32 bits: byte address. Bits [1:0] are ignored.
- `we_i` input, 1 bit: 1 means write, 0 means read.
- `be_i` input, 4 bits: byte enables for writes. Ignored for reads.
- `wdata_i` input, 32 bits: write data.
- `stall_i` input, 1 bit: forces `gnt_o` low. Used for back-pressure testing.
- `gnt_o` output, 1 bit: grant. Combinational.
- `rvalid_o` output, 1 bit: response valid, one cycle per transaction.
- `rdata_o` output, 32 bits: read data.
- `err_o` output, 1 bit: qualifies `rvalid_o`; high when the transaction addressed out of range.

## Operation

- Grant: `gnt_o = req_i & ~stall_i & (pending < MAX_OUTSTANDING)`.
- A transaction is accepted in any cycle with `req_i & gnt_o`.
- There is no response back-pressure. The requester must accept every `rvalid_o`.
- Word index is `addr_i[31:2]`. The access is in range when that index is less than `DEPTH_WORDS`.
- Accepted in-range write: each byte lane k with `be_i[k]=1` is written at the accepting edge. The response carries `rdata_o=0` and `err_o=0`.
- Accepted in-range read: the word is read at the accepting edge. A write accepted in an earlier cycle is visible to it.
- Out-of-range access: any write is dropped. The response carries `rdata_o=ERR_DATA` and `err_o=1`.
- Response path: a LATENCY-deep shift pipeline of {valid, err, data}. Responses come out strictly in acceptance order.
- `pending` counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on accept.
  - −1 on `rvalid_o`.
  - Unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows. A violation is an assertion failure.
- When MAX_OUTSTANDING < LATENCY, grants stall until the oldest response retires. Throughput is then MAX_OUTSTANDING per LATENCY cycles.
- RAM contents are not affected by reset. Their simulation initial value is 0.

## Timing

- Reset values:
  - `gnt_o` is 0 while `rst_i` is high.
  - `rvalid_o=0`, `err_o=0`, `rdata_o=0`.
  - `pending=0` and all pipeline valids cleared.
- Reset asserted mid-operation: in-flight responses are discarded and never produce `rvalid_o`. Writes already accepted remain in the RAM.
- Latency: a transaction accepted in cycle N drives `rvalid_o=1` in cycle N+LATENCY only.
  - With LATENCY=1, the response is registered and appears in the next cycle.
- `rdata_o` and `err_o` are 0 in every cycle where `rvalid_o=0`.
- Back-to-back: a new accept is possible every cycle while `pending < MAX_OUTSTANDING` or a response retires in that same cycle.
  - This is the full-condition bypass: the grant uses the post-decrement count when `rvalid_o` is high.
- `stall_i` only affects `gnt_o`. Responses already in flight continue unaffected.
- Write-then-read to the same word in consecutive cycles returns the new data.
- A read and a write cannot occur in the same cycle because there is a single port.

## Test plan

- Reset, then write 0x1234_5678 with be=4'hF at addr 0x10, then read 0x10 with LATENCY=1. Required: `rvalid_o` in the cycle after the read accept, `rdata_o=0x1234_5678`, `err_o=0`. Both responses arrive in order.
- Partial write be=4'b0100, wdata=0x00AB_0000 to addr 0x10, then read 0x10. Required: `rdata_o=0x12AB_5678`.
- LATENCY=3, MAX_OUTSTANDING=2, `req_i` held high on reads of 0x0, 0x4, 0x8, 0xC. Required: `gnt_o` pattern 1,1,0,1,1…; each `rvalid_o` lands exactly 3 cycles after its accept; data in order.
- Read at byte address 4*DEPTH_WORDS. Required: `rvalid_o=1`, `err_o=1`, `rdata_o=0xDEAD_BEEF`. A write to the same address leaves all in-range RAM words unchanged.
- Hold `stall_i=1` for 5 cycles with `req_i=1`. Required: `gnt_o=0` throughout and no accepts. On `stall_i=0`, grant occurs in that same cycle.
- Assert `rst_i` with two reads in flight. Required: no `rvalid_o` in the following cycles, `pending=0`, and the RAM word written before reset still reads back correctly.
